// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace multiplier MAC back end: default widths,
// accumulator state encoding and the saturation bounds derived from ACC_W.
package wallace_pkg;

  localparam int PW_DEFAULT    = 16;
  localparam int ACC_W_DEFAULT = 24;
  localparam int CNT_W         = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  // Largest and smallest values representable in a w-bit two's-complement accumulator.
  function automatic longint acc_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint acc_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/wallace_mac_acc_if.sv
// Product-term input stream and result output stream of the MAC back end.
interface wallace_mac_acc_if
  import wallace_pkg::*;
#(
  parameter int PW    = PW_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );

endinterface

// File: rtl/wallace_sat_add.sv
// Combinational signed adder that clamps to the ACC_W range and flags when it did.
module wallace_sat_add
  import wallace_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] y,
  output logic                    ovf
);

  localparam logic signed [ACC_W:0] MAX_W = (ACC_W + 1)'(acc_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_W = (ACC_W + 1)'(acc_min(ACC_W));

  logic signed [ACC_W:0] sum_w;

  // One guard bit is enough: the sum of two ACC_W values always fits in ACC_W+1.
  always_comb begin
    sum_w = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    y     = sum_w[ACC_W-1:0];
    ovf   = 1'b0;
    if (sum_w > MAX_W) begin
      y   = MAX_W[ACC_W-1:0];
      ovf = 1'b1;
    end else if (sum_w < MIN_W) begin
      y   = MIN_W[ACC_W-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/wallace_mac_acc.sv
// Saturating multiply-accumulate back end: sums signed product terms of a dot
// product and presents sum, term count and saturation flag in an output register.
module wallace_mac_acc
  import wallace_pkg::*;
#(
  parameter int PW    = PW_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  wallace_mac_acc_if.slave bus
);

  acc_state_t              state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic                    sat_reg, sat_next;
  logic                    out_valid_reg, out_valid_next;
  logic [ACC_W-1:0]        out_data_reg, out_data_next;
  logic [CNT_W-1:0]        out_count_reg, out_count_next;
  logic                    out_sat_reg, out_sat_next;

  logic signed [ACC_W-1:0] term_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    in_ready;
  logic                    accept;
  logic [CNT_W-1:0]        count_inc;

  assign term_ext  = {{(ACC_W - PW){bus.in_data[PW-1]}}, bus.in_data};
  assign in_ready  = !out_valid_reg || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign count_inc = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + 1'b1;

  wallace_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_reg),
    .b   (term_ext),
    .y   (sum),
    .ovf (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      out_sat_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      sat_reg       <= sat_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_count_reg <= out_count_next;
      out_sat_reg   <= out_sat_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    sat_next       = sat_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_count_next = out_count_reg;
    out_sat_next   = out_sat_reg;

    if (out_valid_reg && bus.out_ready) begin
      out_valid_next = 1'b0;
      out_data_next  = '0;
      out_count_next = '0;
      out_sat_next   = 1'b0;
    end

    // IDLE holds a zero accumulator, so the same adder path starts a fresh sum.
    if (accept) begin
      if (bus.in_last) begin
        out_valid_next = 1'b1;
        out_data_next  = sum;
        out_count_next = count_inc;
        out_sat_next   = sat_reg || ovf;
        acc_next       = '0;
        count_next     = '0;
        sat_next       = 1'b0;
        state_next     = IDLE;
      end else begin
        acc_next   = sum;
        count_next = count_inc;
        sat_next   = sat_reg || ovf;
        state_next = ACCUM;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_count = out_count_reg;
  assign bus.out_sat   = out_sat_reg;

endmodule
